// File: rtl/trivium_xor_packer.sv
// trivium_xor_packer: packs serial keystream bits into DATA_W-bit words,
// buffers them in a KS_DEPTH-entry FIFO and XORs each word with one input
// data word (encrypt == decrypt).
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   ks_bit, ks_valid      keystream bit from the generator and its qualifier
//   ks_enable             advance request to the generator (1-cycle response)
//   in_data/valid/ready   data input handshake
//   out_data/valid/ready  registered XOR result handshake
//   ks_overflow           sticky flag: a keystream bit was dropped
module trivium_xor_packer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned KS_DEPTH  = 2,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ks_bit,
    input  logic              ks_valid,
    output logic              ks_enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ks_overflow
);

    localparam int unsigned BC_W  = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W = $clog2(KS_DEPTH + 1);
    localparam int unsigned PTR_W = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;

    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] mem_q [KS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full;
    logic              fifo_nonempty;
    logic              fifo_pop;
    logic              fifo_push;
    logic              slot_free;
    logic              pending;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] push_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(KS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and status decode
    always_comb begin
        fifo_full     = (count_q == CNT_W'(KS_DEPTH));
        fifo_nonempty = (count_q != '0);
        in_ready      = fifo_nonempty && (!out_valid_q || out_ready);
        fifo_pop      = in_valid && in_ready;
        // A pop in the same cycle frees a slot for the push
        slot_free     = !fifo_full || fifo_pop;
        pending       = (bit_cnt_q == BC_W'(DATA_W));
        if (LSB_FIRST) begin
            shifted = (asm_q >> 1) | (DATA_W'(ks_bit) << (DATA_W - 1));
        end else begin
            shifted = (asm_q << 1) | DATA_W'(ks_bit);
        end
    end

    // Generator may deliver one more bit after enable drops, so stop one bit early
    assign ks_enable = !rst && ((count_q < CNT_W'(KS_DEPTH)) ||
                                (bit_cnt_q < BC_W'(DATA_W - 1)));

    // Bit assembler: completes words, holds one pending word when the FIFO is full
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        asm_d     = asm_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        push_word = asm_q;
        if (pending) begin
            if (slot_free) begin
                fifo_push = 1'b1;
                push_word = asm_q;
                if (ks_valid) begin
                    asm_d     = shifted;
                    bit_cnt_d = BC_W'(1);
                end else begin
                    bit_cnt_d = '0;
                end
            end else if (ks_valid) begin
                ovf_d = 1'b1;
            end
        end else if (ks_valid) begin
            asm_d = shifted;
            if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                if (slot_free) begin
                    fifo_push = 1'b1;
                    push_word = shifted;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = BC_W'(DATA_W);
                end
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
        end
    end

    // FIFO pointers/count and registered XOR stage
    always_comb begin
        wr_ptr_d    = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (fifo_pop) begin
            out_data_d  = in_data ^ mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            asm_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            asm_q       <= asm_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: the count gates every read
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign ks_overflow = ovf_q;

endmodule

// File: tb/tb_trivium_xor_packer.sv
// Directed bench for trivium_xor_packer (DATA_W=8, KS_DEPTH=2, LSB_FIRST=1).
// A keystream model builds words from the bits sent; each accepted input
// pushes in_data ^ keystream word to a scoreboard that is checked on output.
module tb_trivium_xor_packer;

    logic       clk;
    logic       rst;
    logic       ks_bit;
    logic       ks_valid;
    logic       ks_enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       ks_overflow;

    int         vectors;
    int         miscompares;

    logic [7:0] ks_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mdl_acc;
    int         mdl_cnt;

    trivium_xor_packer #(
        .DATA_W   (8),
        .KS_DEPTH (2),
        .LSB_FIRST(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ks_bit     (ks_bit),
        .ks_valid   (ks_valid),
        .ks_enable  (ks_enable),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ks_overflow(ks_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keystream model: bit i of a word is the i-th bit received
    task automatic record_bit(input logic b);
        mdl_acc[mdl_cnt] = b;
        mdl_cnt++;
        if (mdl_cnt == 8) begin
            ks_q.push_back(mdl_acc);
            mdl_cnt = 0;
            mdl_acc = 8'h00;
        end
    endtask

    task automatic send_bit(input logic b);
        ks_valid = 1'b1;
        ks_bit   = b;
        record_bit(b);
        step();
        ks_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic model_reset();
        ks_q.delete();
        exp_q.delete();
        mdl_acc = 8'h00;
        mdl_cnt = 0;
    endtask

    initial begin
        logic en_prev;
        int   first_low;
        int   nbits;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ks_bit      = 1'b0;
        ks_valid    = 1'b0;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        model_reset();

        fork
            begin : main_seq
                // Reset state
                step();
                step();
                check("rst_out_valid", 32'(out_valid), 32'h0);
                check("rst_out_data", 32'(out_data), 32'h0);
                check("rst_overflow", 32'(ks_overflow), 32'h0);
                check("rst_in_ready", 32'(in_ready), 32'h0);
                check("rst_ks_enable", 32'(ks_enable), 32'h0);
                rst = 1'b0;
                #1;
                check("post_rst_ks_enable", 32'(ks_enable), 32'h1);

                // T1: bits 1,0,1,1,0,0,0,0 -> 0x0D; 0xFF ^ 0x0D = 0xF2
                send_byte(8'h0D);
                in_data   = 8'hFF;
                in_valid  = 1'b1;
                out_ready = 1'b1;
                #1;
                check("t1_in_ready", 32'(in_ready), 32'h1);
                step();
                in_valid = 1'b0;
                check("t1_out_valid", 32'(out_valid), 32'h1);
                check("t1_out_data", 32'(out_data), 32'hF2);
                step();
                check("t1_out_drop", 32'(out_valid), 32'h0);

                // T4: input offered with empty FIFO is not taken
                in_data  = 8'h33;
                in_valid = 1'b1;
                #1;
                check("t4_in_ready", 32'(in_ready), 32'h0);
                step();
                check("t4_out_valid", 32'(out_valid), 32'h0);
                check("t4_ks_enable", 32'(ks_enable), 32'h1);
                in_valid = 1'b0;

                // T2: two words buffered, output stalled
                send_byte(8'h3C);
                send_byte(8'hC3);
                out_ready = 1'b0;
                in_data   = 8'h11;
                in_valid  = 1'b1;
                step();
                in_data = 8'h22;
                #1;
                check("t2_in_ready_stall", 32'(in_ready), 32'h0);
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("t2_hold_valid", 32'(out_valid), 32'h1);
                    check("t2_hold_data", 32'(out_data), 32'h2D);
                end
                out_ready = 1'b1;
                #1;
                check("t2_in_ready_go", 32'(in_ready), 32'h1);
                step();
                in_valid = 1'b0;
                check("t2_second_word", 32'(out_data), 32'hE1);
                step();
                check("t2_drained", 32'(out_valid), 32'h0);

                // T3: stream bits obeying ks_enable with a one-cycle lag
                en_prev   = ks_enable;
                first_low = -1;
                nbits     = 0;
                for (int i = 0; i < 30; i++) begin
                    ks_valid = en_prev;
                    ks_bit   = 1'($urandom);
                    if (en_prev) begin
                        record_bit(ks_bit);
                        nbits++;
                    end
                    if (!ks_enable && first_low < 0) first_low = i;
                    en_prev = ks_enable;
                    step();
                end
                ks_valid = 1'b0;
                check("t3_enable_fall_cycle", 32'(first_low), 32'd23);
                check("t3_bits_taken", 32'(nbits), 32'd24);
                check("t3_no_overflow", 32'(ks_overflow), 32'h0);
                check("t3_enable_low", 32'(ks_enable), 32'h0);
                ks_valid = 1'b1;
                ks_bit   = 1'b1;
                step();
                ks_valid = 1'b0;
                check("t3_forced_overflow", 32'(ks_overflow), 32'h1);

                // T5: pop while full with a pending word, then drain in order
                out_ready = 1'b1;
                in_data   = 8'h00;
                in_valid  = 1'b1;
                step();
                in_valid = 1'b0;
                check("t5_enable_after_pop", 32'(ks_enable), 32'h1);
                check("t5_overflow_sticky", 32'(ks_overflow), 32'h1);
                check("t5_out_valid", 32'(out_valid), 32'h1);
                in_data  = 8'h5A;
                in_valid = 1'b1;
                step();
                in_data = 8'hC7;
                step();
                in_valid = 1'b0;
                step();
                check("t5_fifo_empty", 32'(in_ready), 32'h0);
                check("t5_all_popped", 32'(ks_q.size()), 32'd0);

                // T6: reset mid-word with an output held
                send_byte(8'h81);
                out_ready = 1'b0;
                in_data   = 8'h0F;
                in_valid  = 1'b1;
                send_bit(1'b1);
                in_valid = 1'b0;
                send_bit(1'b0);
                send_bit(1'b1);
                send_bit(1'b1);
                send_bit(1'b0);
                check("t6_pre_out_valid", 32'(out_valid), 32'h1);
                check("t6_pre_out_data", 32'(out_data), 32'h8E);
                rst = 1'b1;
                step();
                model_reset();
                check("t6_rst_out_valid", 32'(out_valid), 32'h0);
                check("t6_rst_out_data", 32'(out_data), 32'h0);
                check("t6_rst_overflow", 32'(ks_overflow), 32'h0);
                check("t6_rst_in_ready", 32'(in_ready), 32'h0);
                check("t6_rst_ks_enable", 32'(ks_enable), 32'h0);
                rst = 1'b0;
                send_byte(8'hA5);
                out_ready = 1'b1;
                in_data   = 8'hFF;
                in_valid  = 1'b1;
                step();
                in_valid = 1'b0;
                check("t6_fresh_word", 32'(out_data), 32'h5A);
                step();
                check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (in_valid && in_ready) begin
                            vectors++;
                            assert (ks_q.size() > 0) else begin
                                miscompares++;
                                $error("FAIL ks_model_underrun observed=%0d expected=nonzero", ks_q.size());
                            end
                            if (ks_q.size() > 0) exp_q.push_back(in_data ^ ks_q.pop_front());
                        end
                        if (out_valid && out_ready) begin
                            vectors++;
                            assert (exp_q.size() > 0) else begin
                                miscompares++;
                                $error("FAIL unexpected_output observed=0x%0h expected=none", out_data);
                            end
                            if (exp_q.size() > 0) check("sb_out_data", 32'(out_data), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
            begin : watchdog
                #100000;
                vectors++;
                miscompares++;
                $display("FAIL watchdog observed=timeout expected=completion");
            end
        join_any
        disable fork;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
